// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and the
// baud divider calculation. Optional macro UART_RX_PARITY_EN adds the
// PARITY state.
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_IDLE
   } state_t;

   // System clocks per oversampling tick
   function automatic int baud_div(input int clock_freq, input int baud_rate);
      return clock_freq / (baud_rate * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_rx_ext_if.sv
// Receive-side bus: FIFO head word with valid/ready handshake, occupancy
// and single-cycle event pulses.
interface uart_rx_ext_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8
);
   logic [DATA_BITS-1:0]          rx_data;
   logic                          rx_valid;
   logic                          rx_ready;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;
   logic                          frame_error;
   logic                          parity_error;
   logic                          overrun;
   logic                          break_detect;

   modport master (
      output rx_data, rx_valid, fifo_level,
      output frame_error, parity_error, overrun, break_detect,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, fifo_level,
      input  frame_error, parity_error, overrun, break_detect,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO shared by the UART RX and TX paths. A push into a full
// FIFO is dropped and flagged on overrun unless a pop frees the slot in the
// same cycle; a pop on an empty FIFO is ignored.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overrun
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop_ok;
   logic             push_ok;

   assign pop_ok  = pop && (level != '0);
   assign push_ok = push && ((level != (PTR_W+1)'(DEPTH)) || pop_ok);
   assign valid   = (level != '0);
   // Empty FIFO presents zero so the head word is defined after reset
   assign rd_data = valid ? mem[rd_ptr] : '0;

   // Storage array; no reset needed, reads are masked while empty
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // Pointers, occupancy and overrun pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         overrun <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)      level <= level + 1'b1;
         else if (pop_ok && !push_ok) level <= level - 1'b1;
         overrun <= push && !push_ok;
      end
   end
endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with 16x oversampling, 3-sample majority vote, frame/break
// detection and a receive FIFO. Optional macro UART_RX_PARITY_EN enables
// parity checking.
module uart_rx_ext
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0,
   parameter int FIFO_DEPTH = 8
) (
   input  logic          system_clock,
   input  logic          system_reset,
   input  logic          uart_rx,
   uart_rx_ext_if.master bus
);
   localparam int BAUD_DIV = baud_div(CLOCK_FREQ, BAUD_RATE);
   localparam int DIV_W    = $clog2(BAUD_DIV + 1);
   localparam int BIT_W    = $clog2(DATA_BITS);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("DATA_BITS must be 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
      $error("PARITY_ODD must be 0 or 1");
   end
   if (BAUD_DIV < 1) begin : g_bad_baud
      $error("CLOCK_FREQ too low for BAUD_RATE");
   end

   state_t               state;
   logic [1:0]           sync_q;
   logic                 rx_s, rx_d, fall;
   logic [DIV_W-1:0]     div_cnt;
   logic                 os_tick, mid, bit_end, vote;
   logic [3:0]           tick_cnt;
   logic [3:0]           hi_cnt;
   logic [BIT_W-1:0]     bit_idx;
   logic                 stop_idx;
   logic                 samp7, samp8;
   logic [DATA_BITS-1:0] shreg;
   logic                 fe_q, bd_q, push, pop;
   logic                 par_bad;
`ifdef UART_RX_PARITY_EN
   logic                 pe_q;
`endif

   // Two-flop synchronizer plus one delayed copy for edge detection
   always_ff @(posedge system_clock) begin
      if (system_reset) begin
         sync_q <= 2'b11;
         rx_d   <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], uart_rx};
         rx_d   <= sync_q[1];
      end
   end

   assign rx_s = sync_q[1];
   assign fall = rx_d && !rx_s;

   // Oversampling divider, held cleared while idle
   always_ff @(posedge system_clock) begin
      if (system_reset || state == IDLE)       div_cnt <= '0;
      else if (div_cnt == DIV_W'(BAUD_DIV-1))  div_cnt <= '0;
      else                                     div_cnt <= div_cnt + 1'b1;
   end

   assign os_tick = (state != IDLE) && (div_cnt == DIV_W'(BAUD_DIV-1));
   assign mid     = os_tick && (tick_cnt == 4'd9);
   assign bit_end = os_tick && (tick_cnt == 4'd15);
   // Majority of ticks 7, 8 and the live tick-9 sample
   assign vote    = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);

   // Good word is pushed at mid-last-stop-bit
   assign push = mid && (state == STOP) && vote &&
                 (stop_idx == 1'(STOP_BITS-1)) && !par_bad;
   assign pop  = bus.rx_valid && bus.rx_ready;

   // Frame FSM with registered event pulses
   always_ff @(posedge system_clock) begin
      if (system_reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         hi_cnt   <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         samp7    <= 1'b1;
         samp8    <= 1'b1;
         shreg    <= '0;
         fe_q     <= 1'b0;
         bd_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad  <= 1'b0;
         pe_q     <= 1'b0;
`endif
      end else begin
         fe_q <= 1'b0;
         bd_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pe_q <= 1'b0;
`endif
         if (os_tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd7) samp7 <= rx_s;
            if (tick_cnt == 4'd8) samp8 <= rx_s;
         end
         case (state)
            IDLE: if (fall) begin
               state    <= START;
               tick_cnt <= '0;
               bit_idx  <= '0;
               stop_idx <= 1'b0;
`ifdef UART_RX_PARITY_EN
               par_bad  <= 1'b0;
`endif
            end
            START: begin
               if (mid && vote) state <= IDLE;
               else if (bit_end) state <= DATA;
            end
            DATA: begin
               if (mid) shreg <= {vote, shreg[DATA_BITS-1:1]};
               if (bit_end) begin
                  if (bit_idx == BIT_W'(DATA_BITS-1)) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (mid && ((^shreg ^ vote) != (PARITY_ODD != 0))) begin
                  pe_q    <= 1'b1;
                  par_bad <= 1'b1;
               end
               if (bit_end) state <= STOP;
            end
`endif
            STOP: begin
               if (mid) begin
                  if (!vote) begin
                     fe_q   <= 1'b1;
                     bd_q   <= (shreg == '0);
                     hi_cnt <= '0;
                     state  <= WAIT_IDLE;
                  end else if (stop_idx == 1'(STOP_BITS-1)) begin
                     state <= IDLE;
                  end
               end else if (bit_end) begin
                  stop_idx <= 1'b1;
               end
            end
            WAIT_IDLE: if (os_tick) begin
               if (!rx_s)                hi_cnt <= '0;
               else if (hi_cnt == 4'd15) state  <= IDLE;
               else                      hi_cnt <= hi_cnt + 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   assign bus.parity_error = pe_q;
`else
   assign par_bad          = 1'b0;
   assign bus.parity_error = 1'b0;
`endif
   assign bus.frame_error  = fe_q;
   assign bus.break_detect = bd_q;

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (system_clock),
      .rst     (system_reset),
      .push    (push),
      .wr_data (shreg),
      .pop     (pop),
      .rd_data (bus.rx_data),
      .valid   (bus.rx_valid),
      .level   (bus.fifo_level),
      .overrun (bus.overrun)
   );
endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 Parameter CLOCK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in baud.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-005 Parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only with UART_RX_PARITY_EN.
REQ-006 Parameter FIFO_DEPTH, default 8, receive FIFO entries; power of two, 2..64.
REQ-007 system_clock  in  1  sole clock; every register updates on its rising edge.
REQ-008 system_reset  in  1  synchronous, active-high reset.
REQ-009 uart_rx  in  1  asynchronous serial line; idles high.
REQ-010 rx_data  out  DATA_BITS  FIFO head word, LSB first received.
REQ-011 rx_valid  out  1  FIFO not empty.
REQ-012 rx_ready  in  1  consumer accepts; a pop occurs when rx_valid and rx_ready are both high.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-014 frame_error, parity_error, overrun, break_detect  out  1 each  single-cycle event pulses.

Function
REQ-015 uart_rx shall pass through a 2-flop synchronizer whose flops reset to 1.
REQ-016 A tick divider shall pulse os_tick once every BAUD_DIV = CLOCK_FREQ/(BAUD_RATE*16) cycles (16x oversampling); it runs only outside IDLE and clears on IDLE entry.
REQ-017 Each bit shall be resolved by a majority vote of the samples taken at os_tick counts 7, 8 and 9 of its 16-tick bit period.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-019 IDLE->START on a synchronized falling edge; START->IDLE (false start, no pulse) if the start-bit vote is 1, otherwise START->DATA.
REQ-020 DATA shall shift DATA_BITS bits LSB first, then go to PARITY if parity is compiled in, otherwise to STOP.
REQ-021 STOP shall check STOP_BITS bits; if all are 1: push the word and return to IDLE at mid-last-stop-bit.
REQ-022 If any stop bit is 0: discard the word, pulse frame_error, go to WAIT_IDLE; additionally pulse break_detect (same cycle) if all data bits and the stop bit were 0.
REQ-023 WAIT_IDLE->IDLE after the line is sampled high for 16 consecutive os_ticks.
REQ-024 FIFO push latency: the word is visible on rx_data/rx_valid the cycle after the push decision.
REQ-025 FIFO full on push: drop the new word, pulse overrun, keep the existing contents.
REQ-026 If push and pop occur in the same cycle while full, both shall succeed and no overrun shall be raised.
REQ-027 If push and pop occur in the same cycle while empty, the push shall succeed and the pop shall be ignored.
REQ-028 fifo_level shall wrap at neither end; the pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 Reset, including mid-frame, shall force IDLE, empty the FIFO, and set rx_valid=0, fifo_level=0, rx_data=0, all pulses=0, and the synchronizer to 1.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: the PARITY state samples one parity bit per PARITY_ODD; on mismatch parity_error pulses at mid-parity-bit and the word is discarded while the frame continues to STOP.
REQ-031 UART_RX_PARITY_EN undefined: no PARITY state exists and parity_error is tied to 0.

Structure
REQ-032 Shared package uart_pkg shall hold the FSM state enum, the OVERSAMPLE=16 constant and the BAUD_DIV calculation function.
REQ-033 The FIFO shall be a sub-module uart_rx_fifo (parameters WIDTH, DEPTH), reusable by the TX path.

Verification (CLOCK_FREQ=50M, BAUD_RATE=115200, so BAUD_DIV=27)
REQ-034 Frame 0xA5, 8N1 -> rx_data=0xA5, rx_valid=1, fifo_level=1, no error pulses.
REQ-035 Low glitch of 3 bit-periods/16 on an idle line -> no push, FSM back in IDLE, no pulses.
REQ-036 Frame 0x3C with stop bit 0, then all-zero frame -> frame_error for the first, frame_error+break_detect for the second, FIFO empty.
REQ-037 9 frames 0x01..0x09 with rx_ready=0, FIFO_DEPTH=8 -> level 8, one overrun pulse, pops return 0x01..0x08.
REQ-038 With UART_RX_PARITY_EN, PARITY_ODD=0, frame 0x07 carrying parity bit 0 -> parity_error pulse, no push.
REQ-039 system_reset asserted mid-DATA of 0x55 -> rx_valid=0, level 0; the next clean frame 0x55 is received correctly.
